byte_queue: RTL

Downstream stage of the 8-bit deserializer: accepts each completed byte through the deserializer's `data_ready`/`ack_in` handshake and stores it in a small circular FIFO. A consumer drains bytes one per request. The block applies backpressure when full by withholding the acknowledge, so the deserializer holds its word and stays busy.

---
 rtl/byte_queue_if.sv | 27 ++
 rtl/byte_queue.sv | 90 +++++++++
 2 files changed

// File: rtl/byte_queue_if.sv
// Handshake bundle between the deserializer/consumer side (master) and byte_queue (slave).
interface byte_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LenW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             data_ready_in;
    logic             ack_out;
    logic             dequeue_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic [LenW-1:0]  len_out;
    logic             full_out;
    logic             empty_out;

    modport master (
        output data_in, data_ready_in, dequeue_in,
        input  ack_out, data_out, data_valid_out, len_out, full_out, empty_out
    );

    modport slave (
        input  data_in, data_ready_in, dequeue_in,
        output ack_out, data_out, data_valid_out, len_out, full_out, empty_out
    );
endinterface

// File: rtl/byte_queue.sv
// Circular byte FIFO behind the deserializer's data_ready/ack handshake; backpressures by
// withholding the ack while full.
module byte_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input logic         clock,
    input logic         reset,
    byte_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LenW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StWaitLow} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              ack_q, ack_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              full, empty, capture, pop;

    // Full/empty come from pre-edge len, so a same-cycle pop never frees room for a capture.
    assign full  = (len_q == LenW'(DEPTH));
    assign empty = (len_q == '0);
    assign pop   = bus.dequeue_in && !empty;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.data_ready_in && !full) begin
                    capture  = 1'b1;
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    state_d  = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!bus.data_ready_in) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack_d    = capture;
        valid_d  = pop;
        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        len_d    = len_q;
        if (capture && !pop)      len_d = len_q + LenW'(1);
        else if (pop && !capture) len_d = len_q - LenW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (capture) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.ack_out        = ack_q;
    assign bus.data_out       = data_q;
    assign bus.data_valid_out = valid_q;
    assign bus.len_out        = len_q;
    assign bus.full_out       = full;
    assign bus.empty_out      = empty;
endmodule
